// File: rtl/sel_arbiter2_pkg.sv
// Shared types for the two-requester select arbiter: FSM states, select
// encodings and the round-robin pick used from IDLE and GAP.
package common;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GNT_A = 2'd1,
      ARB_GNT_B = 2'd2,
      ARB_GAP   = 2'd3
   } arb_state_t;

   localparam logic ARB_SEL_A = 1'b0;
   localparam logic ARB_SEL_B = 1'b1;

   // On a tie the side that did not own the resource last wins.
   function automatic arb_state_t arb_pick(input logic req_a, input logic req_b,
                                           input logic last_gnt);
      arb_state_t pick;
      pick = ARB_IDLE;
      if (req_a && req_b)
         pick = (last_gnt == ARB_SEL_A) ? ARB_GNT_B : ARB_GNT_A;
      else if (req_a)
         pick = ARB_GNT_A;
      else if (req_b)
         pick = ARB_GNT_B;
      return pick;
   endfunction

endpackage

// File: rtl/sel_arbiter2_if.sv
// Request/grant bundle between the two requesters (master) and the arbiter
// (slave); dbg_state mirrors the arbiter FSM for checkers.
interface sel_arbiter2_if;
   import common::*;

   // Level handshake: a requester raises reqX and holds it for as long as it
   // uses the resource; it may use the mux only while grantX is high, and
   // dropping reqX releases the grant on the next edge.
   logic       reqA;
   logic       reqB;
   logic       grantA;
   logic       grantB;
   logic       select;
   logic       busy;
   logic       timeout;
   arb_state_t dbg_state;

   modport master (
      output reqA, reqB,
      input  grantA, grantB, select, busy, timeout, dbg_state
   );

   modport slave (
      input  reqA, reqB,
      output grantA, grantB, select, busy, timeout, dbg_state
   );

endinterface

// File: rtl/sel_arbiter2_hold_timer.sv
// Grant hold counter: cleared outside a grant, counts grant cycles and
// flags the last allowed cycle. Saturates at MAX_HOLD-1, never wraps.
module hold_timer #(
   parameter int MAX_HOLD = 16
) (
   input  logic clk,
   input  logic rstN,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(MAX_HOLD);
   localparam logic [W-1:0] LAST = W'(MAX_HOLD - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstN || clr)
         cnt <= '0;
      else if (en && (cnt != LAST))
         cnt <= cnt + W'(1);
   end

   assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sel_arbiter2.sv
// Two-requester round-robin arbiter driving a registered mux select, with a
// one-cycle GAP between owners. Optional forced release under ARB_TIMEOUT_EN.
module sel_arbiter2
   import common::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rstN,
   sel_arbiter2_if.slave  bus
);

   arb_state_t state;
   arb_state_t pick;
   logic       last_gnt;
   logic       grant_a;
   logic       grant_b;
   logic       sel;
   logic       busy;
   logic       timeout;
   logic       force_rel;
   logic       in_gnt;

   assign in_gnt = (state == ARB_GNT_A) || (state == ARB_GNT_B);
   assign pick   = arb_pick(bus.reqA, bus.reqB, last_gnt);

`ifdef ARB_TIMEOUT_EN
   hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold_timer (
      .clk     (clk),
      .rstN    (rstN),
      .clr     (!in_gnt),
      .en      (in_gnt),
      .expired (force_rel)
   );
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_HOLD < 2) || in_gnt;
   assign force_rel  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= ARB_IDLE;
         grant_a  <= 1'b0;
         grant_b  <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         sel      <= 1'b0;
         last_gnt <= ARB_SEL_B;
      end else begin
         grant_a <= 1'b0;
         grant_b <= 1'b0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         unique case (state)
            ARB_IDLE, ARB_GAP: begin
               state <= pick;
               if (pick == ARB_GNT_A) begin
                  grant_a  <= 1'b1;
                  busy     <= 1'b1;
                  sel      <= ARB_SEL_A;
                  last_gnt <= ARB_SEL_A;
               end else if (pick == ARB_GNT_B) begin
                  grant_b  <= 1'b1;
                  busy     <= 1'b1;
                  sel      <= ARB_SEL_B;
                  last_gnt <= ARB_SEL_B;
               end
            end
            ARB_GNT_A: begin
               if (!bus.reqA || force_rel) begin
                  state   <= ARB_GAP;
                  timeout <= force_rel;
               end else begin
                  grant_a <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ARB_GNT_B: begin
               if (!bus.reqB || force_rel) begin
                  state   <= ARB_GAP;
                  timeout <= force_rel;
               end else begin
                  grant_b <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.grantA    = grant_a;
   assign bus.grantB    = grant_b;
   assign bus.select    = sel;
   assign bus.busy      = busy;
   assign bus.timeout   = timeout;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_sel_arbiter2.sv
// Directed bench for sel_arbiter2: cycle table plus build-dependent hold
// sequences (forced release with MAX_HOLD=4, or unlimited hold).
module tb_sel_arbiter2;

   logic clk;
   logic rstN;
   int   errors;
   int   checks;

   // Expected output word: {grantA, grantB, select, busy, timeout}
   logic [4:0] exp_q[$];

   typedef struct {
      logic       rst_n;
      logic       a;
      logic       b;
      logic [4:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   sel_arbiter2_if bus();

   sel_arbiter2 #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input logic r, input logic a, input logic b,
                       input logic [4:0] exp, input string name);
      logic [4:0] act;
      logic [4:0] want;
      @(negedge clk);
      rstN     = r;
      bus.reqA = a;
      bus.reqB = b;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      act  = {bus.grantA, bus.grantB, bus.select, bus.busy, bus.timeout};
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s t=%0t got gA/gB/sel/busy/to=%b expected %b",
                  name, $time, act, want);
      end
   endtask

   task automatic add(input logic r, input logic a, input logic b,
                      input logic [4:0] exp, input string name);
      vec_t v;
      v.rst_n = r;
      v.a     = a;
      v.b     = b;
      v.exp   = exp;
      v.name  = name;
      vecs.push_back(v);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rstN     = 1'b0;
      bus.reqA = 1'b0;
      bus.reqB = 1'b0;

      add(0, 1, 1, 5'b00000, "reset0");
      add(0, 1, 1, 5'b00000, "reset1");
      add(0, 1, 1, 5'b00000, "reset2");
      add(1, 1, 0, 5'b10010, "a_first");
      add(1, 1, 0, 5'b10010, "a_hold1");
      add(1, 1, 0, 5'b10010, "a_hold2");
      add(1, 0, 0, 5'b00000, "a_gap");
      add(1, 0, 0, 5'b00000, "idle");
      add(0, 1, 1, 5'b00000, "reset_again");
      add(1, 1, 1, 5'b10010, "tie_to_a");
      add(1, 1, 1, 5'b10010, "tie_a_hold");
      add(1, 0, 1, 5'b00000, "gap_a_to_b");
      add(1, 0, 1, 5'b01110, "b_grant");
      add(1, 1, 1, 5'b01110, "b_hold_a_wait1");
      add(1, 1, 1, 5'b01110, "b_hold_a_wait2");
      add(1, 1, 0, 5'b00100, "gap_b_to_a");
      add(1, 1, 0, 5'b10010, "a_regrant");
      add(1, 0, 1, 5'b00000, "gap_a_to_b2");
      add(1, 0, 1, 5'b01110, "b_grant2");
      add(0, 1, 1, 5'b00000, "reset_mid_b");
      add(1, 1, 1, 5'b10010, "tie_after_reset");
      add(1, 0, 0, 5'b00000, "gap_after_tie");
      add(1, 0, 0, 5'b00000, "idle2");
      add(1, 1, 1, 5'b01110, "tie_rr_to_b");
      add(1, 1, 0, 5'b00100, "gap_b_drop");
      add(1, 1, 0, 5'b10010, "a_after_b");
      add(1, 0, 0, 5'b00000, "gap_end");

      foreach (vecs[i])
         step(vecs[i].rst_n, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      step(0, 0, 0, 5'b00000, "seq_reset");
      step(0, 0, 0, 5'b00000, "seq_reset");

`ifdef ARB_TIMEOUT_EN
      // Both stuck high: 4 A cycles, timeout GAP, 4 B cycles, timeout GAP.
      for (int i = 0; i < 30; i++) begin
         int p;
         p = i % 10;
         if (p < 4)       step(1, 1, 1, 5'b10010, "to_rr_grant_a");
         else if (p == 4) step(1, 1, 1, 5'b00001, "to_rr_gap_a");
         else if (p < 9)  step(1, 1, 1, 5'b01110, "to_rr_grant_b");
         else             step(1, 1, 1, 5'b00101, "to_rr_gap_b");
      end
      step(0, 0, 0, 5'b00000, "seq_reset2");
      // Lone requester is re-granted after each forced release.
      for (int i = 0; i < 20; i++) begin
         if ((i % 5) < 4) step(1, 1, 0, 5'b10010, "to_solo_grant_a");
         else             step(1, 1, 0, 5'b00001, "to_solo_gap");
      end
`else
      for (int i = 0; i < 100; i++)
         step(1, 1, 1, 5'b10010, "long_hold_a");
      step(1, 0, 1, 5'b00000, "long_gap");
      step(1, 0, 1, 5'b01110, "long_then_b");
      step(1, 0, 0, 5'b00100, "long_b_gap");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sel_arbiter2.md
# sel_arbiter2

Two-requester arbiter that owns a shared datapath mux and sequences access to it. Each requester holds a level request. The block grants one requester at a time and drives the registered `select` line that steers the mux. It inserts a one-cycle turnaround between owners and alternates owners round-robin on contention. An optional hold timer forces release of a requester that holds too long.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced release; legal range ≥ 2; only used when the timeout feature is compiled in.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  input  1  rising-edge clock for all state.
- `rstN`  input  1  synchronous active-low reset, sampled on `clk`.
- `reqA`  input  1  requester A level request; held high for the whole use of the resource.
- `reqB`  input  1  requester B level request; same rules as `reqA`.
- `grantA`  output  1  A owns the resource.
- `grantB`  output  1  B owns the resource.
- `select`  output  1  mux steer: 0 = A, 1 = B; registered.
- `busy`  output  1  high whenever either grant is high.
- `timeout`  output  1  one-cycle pulse after a forced release.

## Operation
- States are `ARB_IDLE`, `ARB_GNT_A`, `ARB_GNT_B` and `ARB_GAP`.
- Outputs are Moore outputs:
  - `grantA` = (state == `ARB_GNT_A`).
  - `grantB` = (state == `ARB_GNT_B`).
  - `busy` = `grantA` | `grantB`.
- `ARB_IDLE` and `ARB_GAP` share the same next-state logic:
  - only `reqA` high → `ARB_GNT_A`.
  - only `reqB` high → `ARB_GNT_B`.
  - both high → grant goes to the side opposite `lastGnt`.
  - neither high → `ARB_IDLE`.
- `ARB_GNT_A`: `reqA` sampled low, or forced release → `ARB_GAP`. Otherwise stay. The same rule applies to `ARB_GNT_B` with `reqB`.
- `ARB_GAP` lasts exactly one cycle. No grant is high during it.
- `lastGnt` is 1 bit: 0 = A, 1 = B.
  - Updated on every entry to a GNT state.
  - Reset value is 1, so A wins the first tie.
- `select` loads 0 on entry to `ARB_GNT_A` and 1 on entry to `ARB_GNT_B`. It holds its value in `ARB_IDLE` and `ARB_GAP`, so the mux never toggles without a new grant.
- Forced release (feature on):
  - The hold counter clears on GNT entry and increments every GNT cycle.
  - When counter == `MAX_HOLD`-1 at an edge while in GNT, the next state is `ARB_GAP` and `timeout` is 1 during that `ARB_GAP` cycle.
  - A requester still requesting after forced release gets re-granted only if the other side is idle. Round-robin otherwise gives the grant to the other side.
- Counter width is $clog2(`MAX_HOLD`). The counter saturates and never wraps.
- Reset values with `rstN` low at an edge:
  - state `ARB_IDLE`.
  - `grantA`/`grantB`/`busy`/`timeout`/`select` = 0.
  - `lastGnt` = 1, counter = 0.
- Reset mid-grant drops the grant at that edge, with no `ARB_GAP` and no `timeout`.
- Requests are ignored while `rstN` is low.

## Timing
- Grant latency: a request sampled high at edge k in `ARB_IDLE`/`ARB_GAP` makes the grant high in cycle k+1.
- Release: a request sampled low at edge k makes the grant low in cycle k+1 (`ARB_GAP`). The earliest next grant is in cycle k+2.
- Owner-to-owner dead time is exactly one cycle.
- `select` changes on the same edge the new grant rises.
- Maximum grant length is `MAX_HOLD` cycles (feature on).
- `timeout` is high for exactly one cycle and coincides with `ARB_GAP`.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined: the hold counter and forced release are built, and `timeout` behaves as above.
- Undefined:
  - No counter is instantiated.
  - A grant persists until its request drops.
  - `timeout` is tied to 0.
  - `MAX_HOLD` is ignored.
- The port list is identical in both builds.

## Structure
- Shared package `common` holds:
  - `arb_state_t` enum with `ARB_IDLE`, `ARB_GNT_A`, `ARB_GNT_B`, `ARB_GAP`.
  - constants `ARB_SEL_A` = 1'b0 and `ARB_SEL_B` = 1'b1.
- Sub-module `hold_timer` contains:
  - parameter `MAX_HOLD`.
  - inputs `clk`, `rstN`, `clr`, `en`.
  - output `expired`.
- `hold_timer` is instantiated only under `ARB_TIMEOUT_EN`.
- The FSM, `lastGnt` and `select` stay in the top module.

## Test plan
- Reset: `rstN`=0 with `reqA`=`reqB`=1 for 3 cycles → all outputs 0. After release, `grantA` is high in the cycle following the first sampled edge.
- Single owner: `reqA` rises at edge 0 and falls at edge 5:
  - `grantA`=1 in cycles 1–5, `select`=0.
  - Cycle 6 is `ARB_GAP` with no grant; `busy`=0 from cycle 6.
- Contention: `reqA`=`reqB`=1 from reset exit → A is granted first.
  - Drop `reqA` → one `ARB_GAP` cycle, then `grantB`=1 and `select`=1.
  - Re-raise `reqA` while B is held → A waits until `reqB` drops plus one `ARB_GAP` cycle.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `reqA` and `reqB` stuck at 1.
  - `grantA` high exactly 4 cycles, then `timeout`=1 for one cycle, then `grantB` for 4 cycles.
  - The pattern alternates indefinitely.
- Reset mid-grant: `rstN` low while `grantB`=1 → next cycle `grantB`=0, `select`=0, `timeout`=0. After reset, a tie goes to A.
- Macro undefined: `reqA` held 100 cycles with `reqB`=1 → `grantA` stays 1 throughout, `timeout` stays 0, B is granted only after `reqA` drops.
